// File: rtl/minisrc_io_pkg.sv
// Shared definitions for the MiniSRC input-port family.
// Holds the Status bit-layout offsets and the width helper used for Sel
// and per-channel FIFO counters.
package minisrc_io_pkg;

  // Status word layout: not-empty flags start at bit 0, overflow flags follow.
  localparam int unsigned NOTEMPTY_BASE = 0;

  function automatic int unsigned ovf_base(input int unsigned num_ch);
    return num_ch;
  endfunction

  // ceil(log2(n)), never below 1 so single-entry selects still get a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/in_port_chan.sv
// One input channel: strobe synchroniser, rising-edge detect, FIFO storage,
// pointers, occupancy count and sticky overflow flag.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   strobe_i        asynchronous data-valid strobe
//   data_i          channel data, sampled on the detected strobe edge
//   pop_i           pop the head (ignored when empty)
//   ovf_clr_i       clear the overflow flag (a same-cycle overflow wins)
//   head_o          word at the read pointer
//   not_empty_o     count != 0
//   ovf_o           sticky overflow flag
module in_port_chan
  import minisrc_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  strobe_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  input  logic                  ovf_clr_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  not_empty_o,
  output logic                  ovf_o
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic rise_c, full_c, empty_c, push_c, pop_c, ovf_set_c;

  // Capture control: a pop in the same cycle frees the slot for a push.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], strobe_i};
    edge_d    = sync_q[SYNC_STAGES-1];
    rise_c    = sync_q[SYNC_STAGES-1] & ~edge_q;
    full_c    = (cnt_q == CNT_W'(DEPTH));
    empty_c   = (cnt_q == '0);
    pop_c     = pop_i & ~empty_c;
    push_c    = rise_c & (~full_c | pop_c);
    ovf_set_c = rise_c & full_c & ~pop_c;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (ovf_set_c)      ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
  end

  // Control state; sync/edge flops reset high so a held strobe is not a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      edge_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      edge_q   <= edge_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign not_empty_o = ~empty_c;
  assign ovf_o       = ovf_q;

endmodule

// File: rtl/multi_in_port.sv
// Buffered multi-channel input port for the MiniSRC datapath.
// Ports:
//   Clock, Clear    clock, async active-low reset
//   Strobe          per-channel asynchronous data-valid strobes
//   Input           channel i at [i*DATA_WIDTH_IN +: DATA_WIDTH_IN]
//   Sel             channel addressed by Read, OvfClr and BusMuxIn
//   Read            pop head of channel Sel
//   OvfClr          clear channel Sel's overflow flag
//   IrqEn           per-channel interrupt enable
//   BusMuxIn        head of channel Sel, INIT when empty/out of range (comb.)
//   Status          {overflow[NUM_CH-1:0], not_empty[NUM_CH-1:0]}
//   Irq             registered OR of enabled not-empty flags
module multi_in_port
  import minisrc_io_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH_IN  = 32,
  parameter int unsigned              DATA_WIDTH_OUT = 32,
  parameter int unsigned              NUM_CH         = 2,
  parameter int unsigned              DEPTH          = 4,
  parameter int unsigned              SYNC_STAGES    = 2,
  parameter logic [DATA_WIDTH_OUT-1:0] INIT          = '0
) (
  input  logic                              Clock,
  input  logic                              Clear,
  input  logic [NUM_CH-1:0]                 Strobe,
  input  logic [NUM_CH*DATA_WIDTH_IN-1:0]   Input,
  input  logic [clog2_min1(NUM_CH)-1:0]     Sel,
  input  logic                              Read,
  input  logic                              OvfClr,
  input  logic [NUM_CH-1:0]                 IrqEn,
  output logic [DATA_WIDTH_OUT-1:0]         BusMuxIn,
  output logic [2*NUM_CH-1:0]               Status,
  output logic                              Irq
);

  localparam int unsigned OVF_LSB = ovf_base(NUM_CH);
  localparam int unsigned EXT_W   = (DATA_WIDTH_OUT > DATA_WIDTH_IN) ?
                                    DATA_WIDTH_OUT : DATA_WIDTH_IN;

  logic [NUM_CH-1:0]        sel_hit_c;
  logic [NUM_CH-1:0]        not_empty;
  logic [NUM_CH-1:0]        ovf;
  logic [DATA_WIDTH_IN-1:0] head [NUM_CH];
  logic [DATA_WIDTH_IN-1:0] head_sel_c;
  logic [EXT_W-1:0]         head_ext_c;
  logic                     head_vld_c;
  logic                     irq_q, irq_d;

  // Sel decode; out-of-range values hit no channel.
  always_comb begin
    sel_hit_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(Sel) == 32'(i)) sel_hit_c[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    in_port_chan #(
      .DATA_WIDTH  (DATA_WIDTH_IN),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk         (Clock),
      .rst_n       (Clear),
      .strobe_i    (Strobe[g]),
      .data_i      (Input[g*DATA_WIDTH_IN +: DATA_WIDTH_IN]),
      .pop_i       (Read & sel_hit_c[g]),
      .ovf_clr_i   (OvfClr & sel_hit_c[g]),
      .head_o      (head[g]),
      .not_empty_o (not_empty[g]),
      .ovf_o       (ovf[g])
    );
  end

  // Head mux with zero-extend/truncate to bus width.
  always_comb begin
    head_sel_c = '0;
    head_vld_c = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_hit_c[i] && not_empty[i]) begin
        head_sel_c = head[i];
        head_vld_c = 1'b1;
      end
    end
    head_ext_c = EXT_W'(head_sel_c);
    BusMuxIn   = head_vld_c ? head_ext_c[DATA_WIDTH_OUT-1:0] : INIT;
  end

  always_comb begin
    Status                          = '0;
    Status[NOTEMPTY_BASE +: NUM_CH] = not_empty;
    Status[OVF_LSB +: NUM_CH]       = ovf;
  end

  assign irq_d = |(not_empty & IrqEn);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign Irq = irq_q;

endmodule

// File: tb/tb_multi_in_port.sv
module tb_multi_in_port;

  localparam logic [31:0] INIT_V = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        clear;
  logic [1:0]  strobe;
  logic [63:0] in_bus;
  logic [0:0]  sel;
  logic        rd;
  logic        ovf_clr;
  logic [1:0]  irq_en;
  logic [31:0] bus;
  logic [3:0]  status;
  logic        irq;

  int total = 0;
  int bad   = 0;

  multi_in_port #(
    .DATA_WIDTH_IN  (32),
    .DATA_WIDTH_OUT (32),
    .NUM_CH         (2),
    .DEPTH          (4),
    .SYNC_STAGES    (2),
    .INIT           (INIT_V)
  ) dut (
    .Clock    (clk),
    .Clear    (clear),
    .Strobe   (strobe),
    .Input    (in_bus),
    .Sel      (sel),
    .Read     (rd),
    .OvfClr   (ovf_clr),
    .IrqEn    (irq_en),
    .BusMuxIn (bus),
    .Status   (status),
    .Irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 pulse, 1 read, 2 ovf clear
    int          ch;
    logic [31:0] data;
    logic [1:0]  irqen;
    logic [31:0] exp_bus;
    logic [3:0]  exp_status;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [15];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Checks bus (for channel c), status and irq; Read/OvfClr must be low.
  task automatic check(input string name, input int c, input logic [31:0] eb,
                       input logic [3:0] es, input logic ei);
    sel = 1'(c);
    #1;
    cmp({name, ".bus"}, bus, eb);
    cmp({name, ".status"}, 32'(status), 32'(es));
    cmp({name, ".irq"}, 32'(irq), 32'(ei));
  endtask

  task automatic pulse(input int c, input logic [31:0] d);
    in_bus[c*32 +: 32] = d;
    strobe[c] = 1'b1;
    step();
    strobe[c] = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic read_op(input int c);
    sel = 1'(c);
    rd  = 1'b1;
    step();
    rd  = 1'b0;
    step();
  endtask

  task automatic clr_op(input int c);
    sel     = 1'(c);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_seq [4];

    vecs[0]  = '{0, 0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 4'b0001, 1'b0};
    vecs[1]  = '{1, 0, 32'h0,         2'b00, INIT_V,        4'b0000, 1'b0};
    vecs[2]  = '{0, 1, 32'd1,         2'b00, 32'd1,         4'b0010, 1'b0};
    vecs[3]  = '{0, 1, 32'd2,         2'b00, 32'd1,         4'b0010, 1'b0};
    vecs[4]  = '{0, 1, 32'd3,         2'b00, 32'd1,         4'b0010, 1'b0};
    vecs[5]  = '{0, 1, 32'd4,         2'b00, 32'd1,         4'b0010, 1'b0};
    vecs[6]  = '{0, 1, 32'd5,         2'b00, 32'd1,         4'b1010, 1'b0};
    vecs[7]  = '{1, 1, 32'h0,         2'b00, 32'd2,         4'b1010, 1'b0};
    vecs[8]  = '{1, 1, 32'h0,         2'b00, 32'd3,         4'b1010, 1'b0};
    vecs[9]  = '{1, 1, 32'h0,         2'b00, 32'd4,         4'b1010, 1'b0};
    vecs[10] = '{1, 1, 32'h0,         2'b00, INIT_V,        4'b1000, 1'b0};
    vecs[11] = '{2, 1, 32'h0,         2'b00, INIT_V,        4'b0000, 1'b0};
    vecs[12] = '{1, 1, 32'h0,         2'b00, INIT_V,        4'b0000, 1'b0};
    vecs[13] = '{0, 0, 32'd7,         2'b01, 32'd7,         4'b0001, 1'b1};
    vecs[14] = '{1, 0, 32'h0,         2'b01, INIT_V,        4'b0000, 1'b0};

    clear   = 1'b0;
    strobe  = 2'b01;
    in_bus  = {32'h0, 32'h1111_1111};
    sel     = 1'b0;
    rd      = 1'b0;
    ovf_clr = 1'b0;
    irq_en  = 2'b11;

    // Reset with Strobe[0] held high through release.
    step();
    step();
    check("rst_held", 0, INIT_V, 4'b0000, 1'b0);
    clear = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rst_release", 0, INIT_V, 4'b0000, 1'b0);
    strobe = 2'b00;
    for (int i = 0; i < 4; i++) step();
    check("rst_strobe_drop", 0, INIT_V, 4'b0000, 1'b0);

    // Table-driven single-operation vectors.
    for (int v = 0; v < 15; v++) begin
      irq_en = vecs[v].irqen;
      case (vecs[v].kind)
        0:       pulse(vecs[v].ch, vecs[v].data);
        1:       read_op(vecs[v].ch);
        default: clr_op(vecs[v].ch);
      endcase
      check($sformatf("vec%0d", v), vecs[v].ch, vecs[v].exp_bus,
            vecs[v].exp_status, vecs[v].exp_irq);
    end

    // Both channels strobed together: latency and Irq on channel 1 only.
    irq_en = 2'b10;
    in_bus = {32'hB1, 32'hA0};
    strobe = 2'b11;
    step();
    strobe = 2'b00;
    check("lat_e1", 0, INIT_V, 4'b0000, 1'b0);
    step();
    check("lat_e2", 0, INIT_V, 4'b0000, 1'b0);
    step();
    check("lat_e3_ch0", 0, 32'hA0, 4'b0011, 1'b0);
    check("lat_e3_ch1", 1, 32'hB1, 4'b0011, 1'b0);
    step();
    check("lat_e4_irq", 1, 32'hB1, 4'b0011, 1'b1);
    sel = 1'b1;
    rd  = 1'b1;
    step();
    rd  = 1'b0;
    check("drain1_e1", 1, INIT_V, 4'b0001, 1'b1);
    step();
    check("drain1_e2", 0, 32'hA0, 4'b0001, 1'b0);
    read_op(0);
    check("drain0", 0, INIT_V, 4'b0000, 1'b0);

    // Full channel 0 with a pop on the same edge as a new capture.
    irq_en = 2'b00;
    pulse(0, 32'd5);
    pulse(0, 32'd6);
    pulse(0, 32'd7);
    pulse(0, 32'd8);
    check("full0", 0, 32'd5, 4'b0001, 1'b0);
    in_bus[31:0] = 32'd9;
    strobe[0] = 1'b1;
    step();
    strobe[0] = 1'b0;
    step();
    sel = 1'b0;
    rd  = 1'b1;
    step();
    rd  = 1'b0;
    check("push_pop_full", 0, 32'd6, 4'b0001, 1'b0);
    exp_seq[0] = 32'd6;
    exp_seq[1] = 32'd7;
    exp_seq[2] = 32'd8;
    exp_seq[3] = 32'd9;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("order%0d", i), 0, exp_seq[i], 4'b0001, 1'b0);
      read_op(0);
    end
    check("order_empty", 0, INIT_V, 4'b0000, 1'b0);

    // OvfClr on the same edge as a new overflow: set wins.
    irq_en = 2'b10;
    pulse(1, 32'h10);
    pulse(1, 32'h11);
    pulse(1, 32'h12);
    pulse(1, 32'h13);
    in_bus[63:32] = 32'h14;
    strobe[1] = 1'b1;
    step();
    strobe[1] = 1'b0;
    step();
    sel     = 1'b1;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_set_wins", 1, 32'h10, 4'b1010, 1'b1);
    clr_op(1);
    check("ovf_cleared", 1, 32'h10, 4'b0010, 1'b1);

    // Clear asserted mid-burst acts immediately.
    in_bus[31:0] = 32'h55;
    strobe[0] = 1'b1;
    step();
    strobe[0] = 1'b0;
    step();
    clear = 1'b0;
    check("async_clear", 1, INIT_V, 4'b0000, 1'b0);
    step();
    clear = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("after_clear", 0, INIT_V, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
